// File: rtl/multi_push_detect_pkg.sv
// multi_push_detect_pkg
//   Shared definitions for the multi-channel push-button detector:
//   per-channel FSM state encoding, default parameter values and a
//   counter-width helper.
//   Optional feature macro: MULTI_PUSH_DETECT_LONG_PRESS_EN (see push_chan).
package multi_push_detect_pkg;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } chan_state_e;

    localparam int DEF_CH         = 4;
    localparam int DEF_DIV        = 500000;
    localparam int DEF_DB_CNT     = 3;
    localparam int DEF_HOLD_CNT   = 200;
    localparam int DEF_ACTIVE_LOW = 0;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/push_chan.sv
// push_chan
//   One debounced push-button channel: debounce FSM, debounce counter and
//   (optionally) the long-press hold counter. Advances only on tick_i.
//   Macro MULTI_PUSH_DETECT_LONG_PRESS_EN: when defined the hold counter and
//   long_press_o pulse are built; otherwise long_press_o is tied to 0.
//
//   Ports:
//     clk           clock
//     rst           asynchronous active-high reset
//     tick_i        shared sample tick (one clk wide)
//     s_i           synchronised, polarity-corrected sample (1 = pressed)
//     level_o       debounced pressed level
//     press_o       one-clk pulse on debounced press
//     release_o     one-clk pulse on debounced release
//     long_press_o  one-clk pulse once a press has been held HOLD_CNT ticks
//
//   state         | meaning
//   --------------+---------------------------------------------------
//   IDLE          | released, no pending disagreement
//   PRESS_WAIT    | released, counting consecutive pressed samples
//   PRESSED       | pressed, no pending disagreement
//   RELEASE_WAIT  | pressed, counting consecutive released samples
module push_chan
    import multi_push_detect_pkg::*;
#(
    parameter int DB_CNT   = DEF_DB_CNT,
    parameter int HOLD_CNT = DEF_HOLD_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic s_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam logic [1:0] ST_IDLE         = S_IDLE;
    localparam logic [1:0] ST_PRESS_WAIT   = S_PRESS_WAIT;
    localparam logic [1:0] ST_PRESSED      = S_PRESSED;
    localparam logic [1:0] ST_RELEASE_WAIT = S_RELEASE_WAIT;

    // The counter holds the number of agreeing ticks seen so far; the tick
    // that would make it DB_CNT flips the level instead of incrementing.
    localparam int DB_W = cnt_width(DB_CNT - 1);

    logic [1:0]      state_q, state_d;
    logic [DB_W-1:0] db_q, db_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            db_done;

    // In IDLE/PRESSED db_q is 0, so DB_CNT=1 flips on the first tick.
    assign db_done = (db_q == DB_W'(DB_CNT - 1));

    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (tick_i) begin
            case (state_q)
                ST_IDLE, ST_PRESS_WAIT: begin
                    if (s_i) begin
                        if (db_done) begin
                            state_d = ST_PRESSED;
                            db_d    = '0;
                            level_d = 1'b1;
                            press_d = 1'b1;
                        end else begin
                            state_d = ST_PRESS_WAIT;
                            db_d    = db_q + DB_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                        db_d    = '0;
                    end
                end
                default: begin
                    if (!s_i) begin
                        if (db_done) begin
                            state_d = ST_IDLE;
                            db_d    = '0;
                            level_d = 1'b0;
                            rel_d   = 1'b1;
                        end else begin
                            state_d = ST_RELEASE_WAIT;
                            db_d    = db_q + DB_W'(1);
                        end
                    end else begin
                        state_d = ST_PRESSED;
                        db_d    = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            db_q    <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            db_q    <= db_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

`ifdef MULTI_PUSH_DETECT_LONG_PRESS_EN
    localparam int HOLD_W = cnt_width(HOLD_CNT);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Cleared only by a new press, so a bounce back from RELEASE_WAIT to
    // PRESSED continues the same hold. Saturates at HOLD_CNT: one pulse per
    // press. The releasing tick still counts since level is 1 during it.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (tick_i && level_q && (hold_q != HOLD_W'(HOLD_CNT))) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_W'(HOLD_CNT - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press_o = long_q;
`else
    logic unused_hold_cnt;
    assign unused_hold_cnt = (HOLD_CNT > 0);
    assign long_press_o    = 1'b0;
`endif

endmodule

// File: rtl/multi_push_detect.sv
// multi_push_detect
//   CH independent push-button debouncers sharing one sample tick.
//   Raw inputs are 2-FF synchronised, optionally inverted (ACTIVE_LOW),
//   and fed to one push_chan per channel.
//   Macro MULTI_PUSH_DETECT_LONG_PRESS_EN enables long-press detection;
//   without it long_press_o is constant 0.
//
//   Ports:
//     clk           clock
//     rst           asynchronous active-high reset
//     btn_raw_i     [CH] asynchronous button inputs
//     level_o       [CH] debounced pressed state
//     press_o       [CH] one-clk pulse on debounced press
//     release_o     [CH] one-clk pulse on debounced release
//     long_press_o  [CH] one-clk pulse per press held HOLD_CNT ticks
module multi_push_detect
    import multi_push_detect_pkg::*;
#(
    parameter int CH         = DEF_CH,
    parameter int DIV        = DEF_DIV,
    parameter int DB_CNT     = DEF_DB_CNT,
    parameter int HOLD_CNT   = DEF_HOLD_CNT,
    parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] btn_raw_i,
    output logic [CH-1:0] level_o,
    output logic [CH-1:0] press_o,
    output logic [CH-1:0] release_o,
    output logic [CH-1:0] long_press_o
);

    localparam logic [CH-1:0] INV_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CH-1:0] sync1_q, sync2_q;
    logic [CH-1:0] s;
    logic          tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ INV_MASK;

    generate
        if (DIV > 1) begin : g_tick_div
            localparam int TW = cnt_width(DIV - 1);
            logic [TW-1:0] cnt_q, cnt_d;

            assign tick  = (cnt_q == TW'(DIV - 1));
            assign cnt_d = tick ? '0 : cnt_q + TW'(1);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end
        end else begin : g_tick_every
            assign tick = 1'b1;
        end
    endgenerate

    generate
        for (genvar g = 0; g < CH; g++) begin : g_chan
            push_chan #(
                .DB_CNT   (DB_CNT),
                .HOLD_CNT (HOLD_CNT)
            ) u_chan (
                .clk          (clk),
                .rst          (rst),
                .tick_i       (tick),
                .s_i          (s[g]),
                .level_o      (level_o[g]),
                .press_o      (press_o[g]),
                .release_o    (release_o[g]),
                .long_press_o (long_press_o[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_push_detect.sv
module tb_multi_push_detect;

    localparam int CH   = 4;
    localparam int DIV  = 4;
    localparam int DB   = 3;
    localparam int HOLD = 8;
`ifdef MULTI_PUSH_DETECT_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'hF;
    logic [3:0] level, press, rel, lng;

    multi_push_detect #(
        .CH(CH), .DIV(DIV), .DB_CNT(DB), .HOLD_CNT(HOLD), .ACTIVE_LOW(0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw_i    (btn),
        .level_o      (level),
        .press_o      (press),
        .release_o    (rel),
        .long_press_o (lng)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: debounced level flips after DB consecutive ticks
    // whose sample disagrees with it; hold = ticks spent pressed since press.
    logic [3:0] m_sync1, m_sync2, m_level, m_press, m_rel, m_long;
    int m_tcnt;
    int m_run[4];
    int m_hold[4];

    int prs_cnt[4], rel_cnt[4], lng_cnt[4], prs_cyc[4], lng_cyc[4];

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit         tick;
        logic [3:0] s;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        if (rst) begin
            m_sync1 = '0;
            m_sync2 = '0;
            m_level = '0;
            m_tcnt  = 0;
            for (int c = 0; c < 4; c++) begin
                m_run[c]  = 0;
                m_hold[c] = 0;
            end
            return;
        end
        tick = (m_tcnt == DIV - 1);
        s    = m_sync2;
        if (tick) begin
            for (int c = 0; c < 4; c++) begin
                if (m_level[c] && m_hold[c] < HOLD) begin
                    m_hold[c]++;
                    if (m_hold[c] == HOLD) m_long[c] = LP_EN;
                end
                if (s[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_run[c]   = 0;
                        m_level[c] = s[c];
                        if (s[c]) begin
                            m_press[c] = 1'b1;
                            m_hold[c]  = 0;
                        end else begin
                            m_rel[c] = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
        m_sync2 = m_sync1;
        m_sync1 = btn;
        m_tcnt  = (m_tcnt + 1) % DIV;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 4; c++) begin
            prs_cnt[c] = 0; rel_cnt[c] = 0; lng_cnt[c] = 0;
            prs_cyc[c] = 0; lng_cyc[c] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check4("level", level, m_level);
        check4("press", press, m_press);
        check4("release", rel, m_rel);
        check4("long_press", lng, m_long);
        for (int c = 0; c < 4; c++) begin
            if (press[c] === 1'b1) begin prs_cnt[c]++; prs_cyc[c] = cyc; end
            if (rel[c]   === 1'b1) rel_cnt[c]++;
            if (lng[c]   === 1'b1) begin lng_cnt[c]++; lng_cyc[c] = cyc; end
        end
    endtask

    typedef struct {
        logic [3:0] btn;
        int         cycles;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] lng;
    } row_t;

    row_t rows[$];

    initial begin
        int n;
        int seg;
        int ch;

        // press ch0, release before the hold expires
        rows.push_back('{4'b0001, 20, 4'b0001, 4'b0001, 4'b0000, 4'b0000});
        rows.push_back('{4'b0000, 30, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
        // ch1 toggles every 4 clk: never DB agreeing ticks in a row
        for (int i = 0; i < 10; i++)
            rows.push_back('{(i % 2 == 0) ? 4'b0010 : 4'b0000, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        rows.push_back('{4'b0000, 20, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        // long hold on ch2
        rows.push_back('{4'b0100, 100, 4'b0100, 4'b0100, 4'b0000, {1'b0, LP_EN, 2'b00}});
        rows.push_back('{4'b0000, 30, 4'b0000, 4'b0000, 4'b0100, 4'b0000});
        // simultaneous channels
        rows.push_back('{4'b1011, 20, 4'b1011, 4'b1011, 4'b0000, 4'b0000});
        rows.push_back('{4'b0000, 30, 4'b0000, 4'b0000, 4'b1011, 4'b0000});

        clear_counts();

        // reset held 5 clk with all buttons pressed
        rst = 1'b1;
        btn = 4'hF;
        repeat (5) step();
        check4("rst_level", level, 4'b0000);
        check_int("rst_no_press", prs_cnt[0] + prs_cnt[1] + prs_cnt[2] + prs_cnt[3], 0);
        btn = 4'h0;
        rst = 1'b0;

        for (int i = 0; i < rows.size(); i++) begin
            clear_counts();
            btn = rows[i].btn;
            repeat (rows[i].cycles) step();
            check4($sformatf("row%0d_level", i), level, rows[i].lvl);
            for (int c = 0; c < 4; c++) begin
                check_int($sformatf("row%0d_press_cnt_ch%0d", i, c), prs_cnt[c], int'(rows[i].prs[c]));
                check_int($sformatf("row%0d_release_cnt_ch%0d", i, c), rel_cnt[c], int'(rows[i].rel[c]));
                check_int($sformatf("row%0d_long_cnt_ch%0d", i, c), lng_cnt[c], int'(rows[i].lng[c]));
            end
            if (rows[i].btn == 4'b0100) begin
`ifdef MULTI_PUSH_DETECT_LONG_PRESS_EN
                check_int("ch2_long_delay", lng_cyc[2] - prs_cyc[2], HOLD * DIV);
`else
                check_int("ch2_long_absent", lng_cnt[2], 0);
`endif
            end
        end

        // ch3: reset after two of three qualifying ticks discards progress
        clear_counts();
        btn = 4'b1000;
        n = 0;
        while (m_run[3] < 2 && n < 40) begin
            step();
            n++;
        end
        check_int("ch3_pre_rst_no_press", prs_cnt[3], 0);
        rst = 1'b1;
        repeat (3) step();
        check4("ch3_in_rst_level", level, 4'b0000);
        rst = 1'b0;
        check_int("ch3_rst_no_press", prs_cnt[3], 0);
        n = 0;
        while (prs_cnt[3] == 0 && n < 40) begin
            step();
            n++;
        end
        check_int("ch3_press_after_rst_cycles", n, 2 + DB * DIV - 2);
        check4("ch3_level_after_press", level, 4'b1000);
        btn = 4'b0000;
        repeat (30) step();

        // randomized single-bit toggles with random dwell, occasional reset
        for (int k = 0; k < 250; k++) begin
            ch  = $urandom_range(0, 3);
            btn[ch] = ~btn[ch];
            seg = $urandom_range(1, 40);
            repeat (seg) step();
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                repeat (2) step();
                rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
